mem_bus_arbiter: RTL and testbench

- Shares one single-port synchronous data memory (9-bit address, 9-bit data) between two requesters.
- Port 0 is the processor's memory interface (ADDR/DOUT/W side). Port 1 is a loader/DMA/debug master.
- Round-robin arbitration, one transaction per cycle, in-order read-return tagging with a configurable memory read latency.
- Sits between the processor top level and the memory macro.

---
 rtl/mem_bus_arbiter_pkg.sv | 45 ++++
 rtl/mem_bus_arbiter_rr_arb2.sv | 65 ++++++
 rtl/mem_bus_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_pkg
//
// Shared definitions for the two-port memory bus arbiter:
//   - default address / data widths of the data memory
//   - port index constants (CPU side is port 0, loader/DMA/debug is port 1)
//   - read-return tag layout {valid, port} and a constructor for it
//   - legal range of the memory read latency, plus a clamp helper
// -----------------------------------------------------------------------------
package mem_bus_arbiter_pkg;

  // Default geometry of the data memory macro.
  localparam int AW_DEF = 9;
  localparam int DW_DEF = 9;

  // Port indices. The priority pointer and the tag port field use these.
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  // Supported memory read latency, in cycles after the registered strobe.
  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 4;

  // One entry of the read-return tag pipeline.
  typedef struct packed {
    logic valid;  // entry belongs to an accepted read
    logic port;   // issuing port (PORT_CPU / PORT_AUX)
  } tag_t;

  function automatic tag_t make_tag(input logic valid, input logic port);
    tag_t t;
    t.valid = valid;
    t.port  = port;
    return t;
  endfunction

  // Keep an out-of-range latency parameter inside the supported window so
  // the tag pipeline depth is always well formed.
  function automatic int clamp_read_lat(input int lat);
    if (lat < READ_LAT_MIN) return READ_LAT_MIN;
    if (lat > READ_LAT_MAX) return READ_LAT_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
//
// Two-way request arbiter with a one-bit "last granted" priority pointer.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   req0/req1  in   requests from port 0 / port 1
//   gnt0/gnt1  out  one-hot (or zero) grants, combinational
//
// Grant rules:
//   - a lone request is always granted, back-to-back allowed
//   - on a conflict with FIXED_PRIO = 0 the port not granted most recently
//     wins; with FIXED_PRIO = 1 port 0 always wins
//   - during reset no grant is issued whatever the requests
// The pointer only moves on a cycle that carries a grant, so idle cycles keep
// the fairness history intact. Reset leaves it at "port 1 last granted" so
// port 0 wins the first conflict.
// -----------------------------------------------------------------------------
module rr_arb2
  import mem_bus_arbiter_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  logic last_port;  // port granted most recently

  // Grant decode: depends only on requests, pointer and reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (req0 && req1) begin
        if (FIXED_PRIO || (last_port == PORT_AUX)) begin
          gnt0 = 1'b1;
        end else begin
          gnt1 = 1'b1;
        end
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  // Priority pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_port <= PORT_AUX;
    end else if (gnt0) begin
      last_port <= PORT_CPU;
    end else if (gnt1) begin
      last_port <= PORT_AUX;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares one single-port synchronous data memory between the processor
// memory interface (port 0) and a loader/DMA/debug master (port 1).
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   reqN, weN, addrN, wdataN requester N transaction (held until gntN)
//   gntN                     request accepted this cycle (combinational)
//   rvalidN, rdataN          read return for port N; rdataN is mem_rdata
//                            passed straight through, rvalidN qualifies it
//   mem_en, mem_we           registered memory strobe / write enable
//   mem_addr, mem_wdata      registered memory address / write data
//   mem_rdata                memory read data, valid READ_LAT cycles after
//                            the registered strobe
//
// Handshake: a requester raises reqN with stable weN/addrN/wdataN and keeps
// them stable until it samples gntN high on a rising edge; the transaction is
// accepted on that edge and the requester may change its inputs in the next
// cycle. rvalidN is a single-cycle pulse with no back-pressure; the
// requester must take rdataN in that cycle.
//
// Timing for a read accepted in cycle t:
//   t               gntN = 1
//   t+1             mem_en = 1, mem_we = 0, mem_addr = addrN
//   t+1+READ_LAT    rvalidN = 1, rdataN = mem_rdata
// A READ_LAT+1 deep tag shift register of {valid, port} follows each
// accepted transaction so returns come back in issue order and reach the
// right port. Writes enter the pipeline as invalid entries.
// -----------------------------------------------------------------------------
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int READ_LAT   = 1,
  parameter int FIXED_PRIO = 0
) (
  input  logic          clk,
  input  logic          rst,
  // port 0: processor memory interface
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  // port 1: loader / DMA / debug master
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  // memory macro side
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  // Effective latency; the tag pipeline has LAT+1 stages, indices 0..LAT.
  localparam int LAT = clamp_read_lat(READ_LAT);

  logic accept;     // some port was granted this cycle
  logic accept_rd;  // the accepted transaction is a read
  logic accept_we;  // the accepted transaction is a write

  tag_t tag_q [0:LAT];

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  rr_arb2 #(
    .FIXED_PRIO (FIXED_PRIO != 0)
  ) u_arb (
    .clk  (clk),
    .rst  (rst),
    .req0 (req0),
    .req1 (req1),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  assign accept    = gnt0 | gnt1;
  assign accept_we = (gnt0 & we0) | (gnt1 & we1);
  assign accept_rd = (gnt0 & ~we0) | (gnt1 & ~we1);

  // ---------------------------------------------------------------------------
  // Issue registers
  // ---------------------------------------------------------------------------
  // mem_en / mem_we are strobes and drop on idle cycles; address and write
  // data keep their last value so the memory pins stay quiet when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= accept;
      mem_we <= accept_we;
      if (gnt0) begin
        mem_addr  <= addr0;
        mem_wdata <= wdata0;
      end else if (gnt1) begin
        mem_addr  <= addr1;
        mem_wdata <= wdata1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read-return tag pipeline
  // ---------------------------------------------------------------------------
  // Stage 0 lines up with the issue registers (cycle t+1); stage LAT lines up
  // with valid mem_rdata (cycle t+1+LAT). Reset clears every stage, which
  // discards reads that were in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= LAT; i++) begin
        tag_q[i] <= make_tag(1'b0, PORT_CPU);
      end
    end else begin
      tag_q[0] <= make_tag(accept_rd, gnt1 ? PORT_AUX : PORT_CPU);
      for (int i = 1; i <= LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign rvalid0 = tag_q[LAT].valid && (tag_q[LAT].port == PORT_CPU);
  assign rvalid1 = tag_q[LAT].valid && (tag_q[LAT].port == PORT_AUX);

  // Read data is shared; only rvalidN tells a port the data is its own.
  assign rdata0 = mem_rdata;
  assign rdata1 = mem_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Two arbiter instances share one set of requester inputs:
//   dut_a : READ_LAT = 1, round-robin
//   dut_b : READ_LAT = 3, fixed priority (port 0 wins)
// Each instance drives its own behavioural memory model.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

  localparam int AW = 9;
  localparam int DW = 9;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // shared requester inputs
  logic          r0, w0, r1, w1;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] d0, d1;

  // instance A outputs
  logic          a_gnt0, a_gnt1, a_rv0, a_rv1, a_en, a_we;
  logic [DW-1:0] a_rd0, a_rd1, a_wd, a_mrd;
  logic [AW-1:0] a_addr;
  // instance B outputs
  logic          b_gnt0, b_gnt1, b_rv0, b_rv1, b_en, b_we;
  logic [DW-1:0] b_rd0, b_rd1, b_wd, b_mrd;
  logic [AW-1:0] b_addr;

  mem_bus_arbiter #(.AW(AW), .DW(DW), .READ_LAT(1), .FIXED_PRIO(0)) dut_a (
    .clk(clk), .rst(rst),
    .req0(r0), .we0(w0), .addr0(a0), .wdata0(d0),
    .gnt0(a_gnt0), .rvalid0(a_rv0), .rdata0(a_rd0),
    .req1(r1), .we1(w1), .addr1(a1), .wdata1(d1),
    .gnt1(a_gnt1), .rvalid1(a_rv1), .rdata1(a_rd1),
    .mem_en(a_en), .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wd),
    .mem_rdata(a_mrd)
  );

  mem_bus_arbiter #(.AW(AW), .DW(DW), .READ_LAT(3), .FIXED_PRIO(1)) dut_b (
    .clk(clk), .rst(rst),
    .req0(r0), .we0(w0), .addr0(a0), .wdata0(d0),
    .gnt0(b_gnt0), .rvalid0(b_rv0), .rdata0(b_rd0),
    .req1(r1), .we1(w1), .addr1(a1), .wdata1(d1),
    .gnt1(b_gnt1), .rvalid1(b_rv1), .rdata1(b_rd1),
    .mem_en(b_en), .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wd),
    .mem_rdata(b_mrd)
  );

  // ---------------------------------------------------------------------------
  // Memory models (bench-side preload port writes both)
  // ---------------------------------------------------------------------------
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;

  logic [DW-1:0] mem_a [512];
  logic [DW-1:0] mem_b [512];
  logic [DW-1:0] pa;
  logic [DW-1:0] pb0, pb1, pb2;

  always @(posedge clk) begin
    if (ld_en) begin
      mem_a[ld_addr] <= ld_data;
    end else if (a_en && a_we) begin
      mem_a[a_addr] <= a_wd;
    end
    if (a_en && !a_we) pa <= mem_a[a_addr];
  end
  assign a_mrd = pa;

  always @(posedge clk) begin
    if (ld_en) begin
      mem_b[ld_addr] <= ld_data;
    end else if (b_en && b_we) begin
      mem_b[b_addr] <= b_wd;
    end
    if (b_en && !b_we) pb0 <= mem_b[b_addr];
    pb1 <= pb0;
    pb2 <= pb1;
  end
  assign b_mrd = pb2;

  // ---------------------------------------------------------------------------
  // Scoreboard counters and check tasks
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chk9(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%03h expected 0x%03h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive(input logic q0, input logic e0, input logic [8:0] ad0, input logic [8:0] dt0,
                       input logic q1, input logic e1, input logic [8:0] ad1, input logic [8:0] dt1);
    r0 = q0; w0 = e0; a0 = ad0; d0 = dt0;
    r1 = q1; w1 = e1; a1 = ad1; d1 = dt1;
  endtask

  task automatic go_idle(input int n);
    drive(1'b0, 1'b0, 9'h000, 9'h000, 1'b0, 1'b0, 9'h000, 9'h000);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [8:0] ad, input logic [8:0] dt);
    ld_en = 1'b1; ld_addr = ad; ld_data = dt;
    @(posedge clk);
    #1;
    ld_en = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Vector table: inputs for one cycle, expected grants of both instances in
  // that cycle and expected issue registers of instance A in the next cycle.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic       q0;
    logic       e0;
    logic [8:0] ad0;
    logic [8:0] dt0;
    logic       q1;
    logic       e1;
    logic [8:0] ad1;
    logic [8:0] dt1;
    logic       ga0;
    logic       ga1;
    logic       gb0;
    logic       gb1;
    logic       en;
    logic       we;
    logic [8:0] addr;
    logic [8:0] wdata;
  } vec_t;

  localparam int NV = 9;
  vec_t vec [NV];

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int pulses;

  initial begin
    // conflicts, idle hold, idle keeps pointer, lone-port back-to-back
    vec[0] = '{1'b1, 1'b0, 9'h020, 9'h101, 1'b1, 1'b0, 9'h030, 9'h102, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 9'h020, 9'h101};
    vec[1] = '{1'b1, 1'b0, 9'h020, 9'h101, 1'b1, 1'b0, 9'h030, 9'h102, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 9'h030, 9'h102};
    vec[2] = '{1'b1, 1'b0, 9'h020, 9'h101, 1'b1, 1'b0, 9'h030, 9'h102, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 9'h020, 9'h101};
    vec[3] = '{1'b1, 1'b0, 9'h020, 9'h101, 1'b1, 1'b0, 9'h030, 9'h102, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 9'h030, 9'h102};
    vec[4] = '{1'b0, 1'b0, 9'h1FF, 9'h1EE, 1'b0, 1'b1, 9'h1FD, 9'h1DD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h030, 9'h102};
    vec[5] = '{1'b1, 1'b0, 9'h021, 9'h101, 1'b1, 1'b1, 9'h011, 9'h055, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 9'h021, 9'h101};
    vec[6] = '{1'b0, 1'b0, 9'h021, 9'h101, 1'b1, 1'b1, 9'h011, 9'h055, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 9'h011, 9'h055};
    vec[7] = '{1'b0, 1'b0, 9'h000, 9'h000, 1'b1, 1'b0, 9'h011, 9'h102, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 9'h011, 9'h102};
    vec[8] = '{1'b0, 1'b0, 9'h000, 9'h000, 1'b0, 1'b0, 9'h000, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h011, 9'h102};

    // ---- reset with both requests high ----
    rst = 1'b1;
    drive(1'b1, 1'b0, 9'h020, 9'h101, 1'b1, 1'b0, 9'h030, 9'h102);
    @(posedge clk);
    #1;
    preload(9'h005, 9'h1A3);
    preload(9'h001, 9'h011);
    preload(9'h002, 9'h022);
    preload(9'h003, 9'h033);
    preload(9'h010, 9'h000);
    chk1("rst_gnt0_a", a_gnt0, 1'b0);
    chk1("rst_gnt1_a", a_gnt1, 1'b0);
    chk1("rst_gnt0_b", b_gnt0, 1'b0);
    chk1("rst_en_a", a_en, 1'b0);
    chk1("rst_we_a", a_we, 1'b0);
    chk9("rst_addr_a", a_addr, 9'h000);
    chk1("rst_rv0_a", a_rv0, 1'b0);
    chk1("rst_rv1_b", b_rv1, 1'b0);

    // ---- vector table, starting in the first cycle after release ----
    rst = 1'b0;
    for (int i = 0; i < NV; i++) begin
      drive(vec[i].q0, vec[i].e0, vec[i].ad0, vec[i].dt0,
            vec[i].q1, vec[i].e1, vec[i].ad1, vec[i].dt1);
      @(negedge clk);
      chk1($sformatf("v%0d_gnt0_a", i), a_gnt0, vec[i].ga0);
      chk1($sformatf("v%0d_gnt1_a", i), a_gnt1, vec[i].ga1);
      chk1($sformatf("v%0d_gnt0_b", i), b_gnt0, vec[i].gb0);
      chk1($sformatf("v%0d_gnt1_b", i), b_gnt1, vec[i].gb1);
      @(posedge clk);
      #1;
      chk1($sformatf("v%0d_mem_en", i), a_en, vec[i].en);
      chk1($sformatf("v%0d_mem_we", i), a_we, vec[i].we);
      chk9($sformatf("v%0d_mem_addr", i), a_addr, vec[i].addr);
      chk9($sformatf("v%0d_mem_wdata", i), a_wd, vec[i].wdata);
    end

    // ---- single port-0 read, READ_LAT = 1 ----
    go_idle(6);
    drive(1'b1, 1'b0, 9'h005, 9'h000, 1'b0, 1'b0, 9'h000, 9'h000);
    @(negedge clk);
    chk1("sr_gnt0", a_gnt0, 1'b1);
    chk1("sr_gnt1", a_gnt1, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 9'h000, 9'h000, 1'b0, 1'b0, 9'h000, 9'h000);
    chk1("sr_mem_en", a_en, 1'b1);
    chk1("sr_mem_we", a_we, 1'b0);
    chk9("sr_mem_addr", a_addr, 9'h005);
    chk1("sr_rv0_early", a_rv0, 1'b0);
    @(posedge clk); #1;
    chk1("sr_rv0", a_rv0, 1'b1);
    chk9("sr_rdata0", a_rd0, 9'h1A3);
    chk1("sr_rv1", a_rv1, 1'b0);
    @(posedge clk); #1;
    chk1("sr_rv0_after", a_rv0, 1'b0);

    // ---- port-1 write then read of the same address ----
    go_idle(6);
    drive(1'b0, 1'b0, 9'h000, 9'h000, 1'b1, 1'b1, 9'h010, 9'h0FF);
    @(negedge clk);
    chk1("wr_gnt1", a_gnt1, 1'b1);
    @(posedge clk); #1;
    chk1("wr_mem_en", a_en, 1'b1);
    chk1("wr_mem_we", a_we, 1'b1);
    chk9("wr_mem_wdata", a_wd, 9'h0FF);
    drive(1'b0, 1'b0, 9'h000, 9'h000, 1'b1, 1'b0, 9'h010, 9'h000);
    @(negedge clk);
    chk1("rd_gnt1", a_gnt1, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 9'h000, 9'h000, 1'b0, 1'b0, 9'h000, 9'h000);
    chk1("wtr_rv1_t2", a_rv1, 1'b0);
    chk1("wtr_mem_we_t2", a_we, 1'b0);
    @(posedge clk); #1;
    chk1("wtr_rv1_t3", a_rv1, 1'b1);
    chk9("wtr_rdata1", a_rd1, 9'h0FF);
    chk1("wtr_rv0_t3", a_rv0, 1'b0);
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (a_rv1 || a_rv0) pulses++;
    end
    chk9("wtr_extra_pulses", 9'(pulses), 9'd0);

    // ---- pipelined reads on instance B, READ_LAT = 3 ----
    go_idle(8);
    for (int k = 0; k < 8; k++) begin
      case (k)
        0: drive(1'b1, 1'b0, 9'h001, 9'h000, 1'b0, 1'b0, 9'h000, 9'h000);
        1: drive(1'b0, 1'b0, 9'h000, 9'h000, 1'b1, 1'b0, 9'h002, 9'h000);
        2: drive(1'b1, 1'b0, 9'h003, 9'h000, 1'b0, 1'b0, 9'h000, 9'h000);
        default: drive(1'b0, 1'b0, 9'h000, 9'h000, 1'b0, 1'b0, 9'h000, 9'h000);
      endcase
      if (k < 3) begin
        @(negedge clk);
        chk1($sformatf("pl_gnt_k%0d", k), (k == 1) ? b_gnt1 : b_gnt0, 1'b1);
      end
      @(posedge clk); #1;
      chk1($sformatf("pl_rv0_t%0d", k + 1), b_rv0, (k + 1 == 4) || (k + 1 == 6));
      chk1($sformatf("pl_rv1_t%0d", k + 1), b_rv1, (k + 1 == 5));
      if (k + 1 == 4) chk9("pl_rdata0_a1", b_rd0, 9'h011);
      if (k + 1 == 5) chk9("pl_rdata1_a2", b_rd1, 9'h022);
      if (k + 1 == 6) chk9("pl_rdata0_a3", b_rd0, 9'h033);
    end

    // ---- reset pulse while a read is in flight ----
    go_idle(8);
    drive(1'b1, 1'b0, 9'h005, 9'h000, 1'b0, 1'b0, 9'h000, 9'h000);
    @(negedge clk);
    chk1("mr_gnt0_a", a_gnt0, 1'b1);
    chk1("mr_gnt0_b", b_gnt0, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 9'h000, 9'h000, 1'b0, 1'b0, 9'h000, 9'h000);
    rst = 1'b1;
    #1;
    chk1("mr_mem_en_cleared", a_en, 1'b0);
    #1;
    rst = 1'b0;
    pulses = 0;
    for (int k = 2; k <= 6; k++) begin
      @(posedge clk); #1;
      if (a_rv0 || a_rv1 || b_rv0 || b_rv1) pulses++;
    end
    chk9("mr_rvalid_pulses", 9'(pulses), 9'd0);
    // Port 0 was granted last, so without the reset port 1 would win here.
    drive(1'b1, 1'b0, 9'h020, 9'h000, 1'b1, 1'b0, 9'h030, 9'h000);
    @(negedge clk);
    chk1("mr_ptr_gnt0_a", a_gnt0, 1'b1);
    chk1("mr_ptr_gnt1_a", a_gnt1, 1'b0);
    chk1("mr_ptr_gnt0_b", b_gnt0, 1'b1);
    @(posedge clk); #1;
    go_idle(6);

    // ---- report ----
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
